// File: rtl/gshare_predictor.sv
// gshare direction predictor: PC xor speculative global history indexes a table of
// 2-bit saturating counters. An in-order in-flight queue keeps the lookup index,
// predicted direction and history snapshot so training and history repair are exact.
// Optional statistics counters are enabled with the GSHARE_STATS_EN macro.
module gshare_predictor #(
   parameter int unsigned PC_W     = 32,
   parameter int unsigned PC_SHIFT = 2,
   parameter int unsigned IDX_W    = 6,
   parameter int unsigned HIST_W   = 6,
   parameter int unsigned DEPTH    = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       lookup_valid,
   input  logic [PC_W-1:0]            lookup_pc,
   output logic                       lookup_ready,
   output logic                       pred_taken,
   input  logic                       resolve_valid,
   input  logic                       resolve_taken,
   output logic                       mispredict,
   output logic [$clog2(DEPTH):0]     inflight_cnt
`ifdef GSHARE_STATS_EN
   ,
   output logic [15:0]                stat_lookups,
   output logic [15:0]                stat_mispredicts
`endif
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned TBL_N = 1 << IDX_W;

   typedef struct packed {
      logic [IDX_W-1:0]  idx;
      logic              pred;
      logic [HIST_W-1:0] ghr;
   } entry_t;

   logic [1:0]        table_q [TBL_N];
   entry_t            fifo_q  [DEPTH];
   logic [HIST_W-1:0] ghr_q, ghr_d;
   logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              mispredict_q;

   logic [IDX_W-1:0]  ghr_ext, idx;
   logic              empty, full, pop, accept, mispredict_now;
   entry_t            head, new_entry;
   logic [1:0]        ctr_old, ctr_new;
   logic [HIST_W-1:0] ghr_spec, ghr_fix;

   // Bits not needed for indexing or history repair.
   logic unused_pc, unused_bits;
   assign unused_pc   = ^lookup_pc;
   assign unused_bits = head.ghr[HIST_W-1];

   assign head  = fifo_q[head_q];
   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == CNT_W'(DEPTH));

   // Index formation and same-cycle handshake/prediction.
   always_comb begin
      ghr_ext                = '0;
      ghr_ext[HIST_W-1:0]    = ghr_q;
      idx                    = lookup_pc[PC_SHIFT +: IDX_W] ^ ghr_ext;
      pop                    = resolve_valid && !empty;
      mispredict_now         = pop && (resolve_taken != head.pred);
      lookup_ready           = !full && !mispredict_now;
      accept                 = lookup_valid && lookup_ready;
      pred_taken             = accept ? table_q[idx][1] : 1'b0;
      new_entry.idx          = idx;
      new_entry.pred         = pred_taken;
      new_entry.ghr          = ghr_q;
   end

   // History shift: speculative (fetch) and repaired (mispredict) variants.
   if (HIST_W == 1) begin : g_hist_one
      assign ghr_spec = pred_taken;
      assign ghr_fix  = resolve_taken;
   end else begin : g_hist_multi
      assign ghr_spec = {ghr_q[HIST_W-2:0], pred_taken};
      assign ghr_fix  = {head.ghr[HIST_W-2:0], resolve_taken};
   end

   // Saturating counter update for the resolving entry.
   always_comb begin
      ctr_old = table_q[head.idx];
      ctr_new = ctr_old;
      if (resolve_taken) begin
         if (ctr_old != 2'b11) ctr_new = ctr_old + 2'b01;
      end else begin
         if (ctr_old != 2'b00) ctr_new = ctr_old - 2'b01;
      end
   end

   // Queue pointers, occupancy and history next state; a mispredict flushes everything.
   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      cnt_d  = cnt_q;
      ghr_d  = ghr_q;
      if (mispredict_now) begin
         head_d = '0;
         tail_d = '0;
         cnt_d  = '0;
         ghr_d  = ghr_fix;
      end else begin
         if (accept) begin
            tail_d = tail_q + 1'b1;
            ghr_d  = ghr_spec;
         end
         if (pop) head_d = head_q + 1'b1;
         cnt_d = cnt_q + CNT_W'(accept) - CNT_W'(pop);
      end
   end

   // Control state registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head_q       <= '0;
         tail_q       <= '0;
         cnt_q        <= '0;
         ghr_q        <= '0;
         mispredict_q <= 1'b0;
      end else begin
         head_q       <= head_d;
         tail_q       <= tail_d;
         cnt_q        <= cnt_d;
         ghr_q        <= ghr_d;
         mispredict_q <= mispredict_now;
      end
   end

   // Pattern table: trained only by popped (right-path) entries.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < int'(TBL_N); i++) table_q[i] <= 2'b01;
      end else if (pop) begin
         table_q[head.idx] <= ctr_new;
      end
   end

   // In-flight entry storage.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < int'(DEPTH); i++) fifo_q[i] <= '0;
      end else if (accept) begin
         fifo_q[tail_q] <= new_entry;
      end
   end

   assign mispredict   = mispredict_q;
   assign inflight_cnt = cnt_q;

`ifdef GSHARE_STATS_EN
   logic [15:0] stat_lookups_q, stat_mispredicts_q;

   // Event counters, free-running with natural 16-bit wrap.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stat_lookups_q     <= '0;
         stat_mispredicts_q <= '0;
      end else begin
         if (accept)         stat_lookups_q     <= stat_lookups_q + 16'd1;
         if (mispredict_now) stat_mispredicts_q <= stat_mispredicts_q + 16'd1;
      end
   end

   assign stat_lookups     = stat_lookups_q;
   assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed self-checking bench for gshare_predictor (default parameters).
module tb_gshare_predictor;

   logic        clk = 1'b0;
   logic        reset;
   logic        lookup_valid;
   logic [31:0] lookup_pc;
   logic        lookup_ready;
   logic        pred_taken;
   logic        resolve_valid;
   logic        resolve_taken;
   logic        mispredict;
   logic [2:0]  inflight_cnt;
`ifdef GSHARE_STATS_EN
   logic [15:0] stat_lookups;
   logic [15:0] stat_mispredicts;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   logic [5:0] ghr_m;

   gshare_predictor dut (
      .clk           (clk),
      .reset         (reset),
      .lookup_valid  (lookup_valid),
      .lookup_pc     (lookup_pc),
      .lookup_ready  (lookup_ready),
      .pred_taken    (pred_taken),
      .resolve_valid (resolve_valid),
      .resolve_taken (resolve_taken),
      .mispredict    (mispredict),
      .inflight_cnt  (inflight_cnt)
`ifdef GSHARE_STATS_EN
      ,
      .stat_lookups     (stat_lookups),
      .stat_mispredicts (stat_mispredicts)
`endif
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One lookup steered to table entry 'target', then its resolve next cycle.
   task automatic train(input logic [5:0] target, input logic taken, input logic exp_pred,
                        input logic [1:0] exp_ctr);
      logic [5:0] snap;
      logic [7:0] pcb;
      snap         = ghr_m;
      pcb          = {target ^ ghr_m, 2'b00};
      lookup_pc    = {24'h0, pcb};
      lookup_valid = 1'b1;
      #1;
      check_eq("train_pred", {31'h0, pred_taken}, {31'h0, exp_pred});
      tick();
      lookup_valid  = 1'b0;
      ghr_m         = {ghr_m[4:0], exp_pred};
      resolve_valid = 1'b1;
      resolve_taken = taken;
      tick();
      resolve_valid = 1'b0;
      if (taken != exp_pred) ghr_m = {snap[4:0], taken};
      check_eq("train_pulse", {31'h0, mispredict}, {31'h0, (taken != exp_pred)});
      check_eq("train_ctr", {30'h0, dut.table_q[target]}, {30'h0, exp_ctr});
      check_eq("train_ghr", {26'h0, dut.ghr_q}, {26'h0, ghr_m});
   endtask

   initial begin
      reset         = 1'b0;
      lookup_valid  = 1'b0;
      lookup_pc     = '0;
      resolve_valid = 1'b0;
      resolve_taken = 1'b0;
      repeat (2) tick();
      reset = 1'b1;
      tick();

      // Reset state
      check_eq("rst_cnt", {29'h0, inflight_cnt}, 32'd0);
      check_eq("rst_misp", {31'h0, mispredict}, 32'd0);
      check_eq("rst_ready", {31'h0, lookup_ready}, 32'd1);
      check_eq("rst_pred", {31'h0, pred_taken}, 32'd0);
      check_eq("rst_ghr", {26'h0, dut.ghr_q}, 32'h0);
      check_eq("rst_ctr", {30'h0, dut.table_q[6'h10]}, 32'd1);

      // First lookup pc=0x40 -> idx 0x10, predicts not taken, resolves taken
      lookup_pc = 32'h40; lookup_valid = 1'b1; #1;
      check_eq("l1_pred", {31'h0, pred_taken}, 32'd0);
      check_eq("l1_ready", {31'h0, lookup_ready}, 32'd1);
      tick(); lookup_valid = 1'b0;
      check_eq("l1_cnt", {29'h0, inflight_cnt}, 32'd1);
      check_eq("l1_ghr", {26'h0, dut.ghr_q}, 32'h0);
      resolve_valid = 1'b1; resolve_taken = 1'b1; #1;
      check_eq("r1_ready_blk", {31'h0, lookup_ready}, 32'd0);
      check_eq("r1_misp_early", {31'h0, mispredict}, 32'd0);
      tick(); resolve_valid = 1'b0;
      check_eq("r1_misp", {31'h0, mispredict}, 32'd1);
      check_eq("r1_ghr", {26'h0, dut.ghr_q}, 32'h01);
      check_eq("r1_ctr", {30'h0, dut.table_q[6'h10]}, 32'd2);
      check_eq("r1_cnt", {29'h0, inflight_cnt}, 32'd0);
      tick();
      check_eq("r1_misp_end", {31'h0, mispredict}, 32'd0);

      // Fill queue: idx 0x11,0x12,0x14,0x18, ghr -> 0x10
      lookup_pc = 32'h40; lookup_valid = 1'b1;
      repeat (4) tick();
      check_eq("full_cnt", {29'h0, inflight_cnt}, 32'd4);
      check_eq("full_ready", {31'h0, lookup_ready}, 32'd0);
      check_eq("full_pred", {31'h0, pred_taken}, 32'd0);
      check_eq("full_ghr", {26'h0, dut.ghr_q}, 32'h10);
      tick();
      check_eq("full_ghr_hold", {26'h0, dut.ghr_q}, 32'h10);
      check_eq("full_cnt_hold", {29'h0, inflight_cnt}, 32'd4);
      // Correct resolve with lookup while full: lookup still blocked
      resolve_valid = 1'b1; resolve_taken = 1'b0; #1;
      check_eq("fullres_ready", {31'h0, lookup_ready}, 32'd0);
      tick(); lookup_valid = 1'b0;
      check_eq("fullres_cnt", {29'h0, inflight_cnt}, 32'd3);
      repeat (3) tick();
      resolve_valid = 1'b0;
      check_eq("drain_cnt", {29'h0, inflight_cnt}, 32'd0);
      check_eq("drain_ghr", {26'h0, dut.ghr_q}, 32'h10);
      check_eq("drain_ctr", {30'h0, dut.table_q[6'h12]}, 32'd0);

      // Occupancy 2 with same-cycle correct resolve and lookup
      lookup_pc = 32'h0; lookup_valid = 1'b1; #1;
      check_eq("occ_pred_t", {31'h0, pred_taken}, 32'd1);
      tick(); #1;
      check_eq("occ_pred_nt", {31'h0, pred_taken}, 32'd0);
      tick();
      check_eq("occ_cnt2", {29'h0, inflight_cnt}, 32'd2);
      check_eq("occ_ghr", {26'h0, dut.ghr_q}, 32'h02);
      resolve_valid = 1'b1; resolve_taken = 1'b1; #1;
      check_eq("occ_ready", {31'h0, lookup_ready}, 32'd1);
      tick(); lookup_valid = 1'b0;
      check_eq("occ_cnt_same", {29'h0, inflight_cnt}, 32'd2);
      check_eq("occ_ghr2", {26'h0, dut.ghr_q}, 32'h04);
      check_eq("occ_ctr", {30'h0, dut.table_q[6'h10]}, 32'd3);
      resolve_taken = 1'b0;
      repeat (2) tick();
      resolve_valid = 1'b0;
      check_eq("occ_drain", {29'h0, inflight_cnt}, 32'd0);

      // Three lookups (idx 0x14,0x18,0x00), mispredict on the second flushes
      lookup_pc = 32'h40; lookup_valid = 1'b1;
      repeat (3) tick();
      lookup_valid = 1'b0;
      check_eq("fl_cnt", {29'h0, inflight_cnt}, 32'd3);
      check_eq("fl_ghr", {26'h0, dut.ghr_q}, 32'h20);
      resolve_valid = 1'b1; resolve_taken = 1'b0;
      tick();
      resolve_taken = 1'b1; #1;
      check_eq("fl_ready", {31'h0, lookup_ready}, 32'd0);
      tick();
      check_eq("fl_misp", {31'h0, mispredict}, 32'd1);
      check_eq("fl_cnt0", {29'h0, inflight_cnt}, 32'd0);
      check_eq("fl_ghr_fix", {26'h0, dut.ghr_q}, 32'h11);
      check_eq("fl_ctr_trained", {30'h0, dut.table_q[6'h18]}, 32'd1);
      check_eq("fl_ctr_flushed", {30'h0, dut.table_q[6'h00]}, 32'd1);
      // Resolve on empty queue is ignored
      check_eq("empty_ready", {31'h0, lookup_ready}, 32'd1);
      tick(); resolve_valid = 1'b0;
      check_eq("empty_misp", {31'h0, mispredict}, 32'd0);
      check_eq("empty_ctr", {30'h0, dut.table_q[6'h00]}, 32'd1);
      check_eq("empty_ghr", {26'h0, dut.ghr_q}, 32'h11);
      check_eq("empty_cnt", {29'h0, inflight_cnt}, 32'd0);

      // Saturation on entry 0x2A
      ghr_m = 6'h11;
      train(6'h2A, 1'b1, 1'b0, 2'b10);
      train(6'h2A, 1'b1, 1'b1, 2'b11);
      train(6'h2A, 1'b1, 1'b1, 2'b11);
      train(6'h2A, 1'b0, 1'b1, 2'b10);
      train(6'h2A, 1'b0, 1'b1, 2'b01);
      train(6'h2A, 1'b0, 1'b0, 2'b00);
      train(6'h2A, 1'b0, 1'b0, 2'b00);

      // Asynchronous reset mid-operation
      lookup_pc = 32'h0; lookup_valid = 1'b1;
      tick(); lookup_valid = 1'b0;
      #2 reset = 1'b0;
      #1;
      check_eq("mrst_cnt", {29'h0, inflight_cnt}, 32'd0);
      check_eq("mrst_ghr", {26'h0, dut.ghr_q}, 32'h0);
      check_eq("mrst_ctr", {30'h0, dut.table_q[6'h2A]}, 32'd1);
      check_eq("mrst_ctr10", {30'h0, dut.table_q[6'h10]}, 32'd1);
      #2 reset = 1'b1;
      tick();
      ghr_m = 6'h00;

      // 5 lookups, 2 mispredicts
      train(6'h33, 1'b1, 1'b0, 2'b10);
      train(6'h33, 1'b1, 1'b1, 2'b11);
      train(6'h33, 1'b0, 1'b1, 2'b10);
      train(6'h33, 1'b1, 1'b1, 2'b11);
      train(6'h33, 1'b1, 1'b1, 2'b11);
`ifdef GSHARE_STATS_EN
      check_eq("stat_lookups", {16'h0, stat_lookups}, 32'd5);
      check_eq("stat_mispredicts", {16'h0, stat_mispredicts}, 32'd2);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
